// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one fixed-latency memory between the CPU and a DMA requester.
// Each grant runs IDLE -> ISSUE -> WAIT (MEM_LAT cycles) -> DONE with a one-cycle ack.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_ack,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner
);
    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              owner_q, owner_d;
    logic              cmd_we_q, cmd_we_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              dma_ack_q, dma_ack_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;
    logic              grant_dma;

    // On a tie the port that was not served last wins.
    assign grant_dma = dma_req & (~cpu_req | ~owner_q);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        owner_d     = owner_q;
        cmd_we_d    = cmd_we_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_ack_d   = 1'b0;
        dma_ack_d   = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;
        case (state_q)
            IDLE: if (cpu_req | dma_req) begin
                state_d     = ISSUE;
                owner_d     = grant_dma;
                cmd_we_d    = grant_dma ? dma_we : cpu_we;
                mem_addr_d  = grant_dma ? dma_addr : cpu_addr;
                mem_wdata_d = grant_dma ? dma_wdata : cpu_wdata;
                mem_en_d    = 1'b1;
                mem_we_d    = cmd_we_d;
            end
            ISSUE: begin
                state_d = WAIT;
                cnt_d   = CW'(MEM_LAT - 1);
            end
            WAIT: if (cnt_q == '0) begin
                state_d     = DONE;
                cpu_ack_d   = ~owner_q;
                dma_ack_d   = owner_q;
                cpu_rdata_d = (!cmd_we_q && !owner_q) ? mem_rdata : cpu_rdata_q;
                dma_rdata_d = (!cmd_we_q && owner_q) ? mem_rdata : dma_rdata_q;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            owner_q     <= 1'b1;
            cmd_we_q    <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_ack_q   <= 1'b0;
            dma_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            owner_q     <= owner_d;
            cmd_we_q    <= cmd_we_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_ack_q   <= cpu_ack_d;
            dma_ack_q   <= dma_ack_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
        end
    end

    assign cpu_ack   = cpu_ack_q;
    assign dma_ack   = dma_ack_q;
    assign cpu_rdata = cpu_rdata_q;
    assign dma_rdata = dma_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = state_q != IDLE;
    assign owner     = owner_q;
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the multicycle MIPS CPU's single unified instruction/data memory with a DMA/loader requester. It sits between `top`'s memory interface and the memory array. It serialises accesses with round-robin fairness, sequences each access through a fixed-latency memory, and returns a one-cycle acknowledge with registered read data to the winning requester.

## Interface
- `ADDR_W`, 32, address width of both requesters and memory
- `DATA_W`, 32, data width
- `MEM_LAT`, 1, memory read latency in cycles (legal 1..4); `mem_rdata` is valid `MEM_LAT` cycles after the cycle `mem_en` is high

Ports:
- `clk` in 1: single clock, all state on rising edge
- `reset` in 1: asynchronous, active-low; low clears all state immediately
- `cpu_req` in 1: CPU access request, held until `cpu_ack`
- `cpu_we` in 1: CPU write (1) / read (0)
- `cpu_addr` in ADDR_W: CPU byte address
- `cpu_wdata` in DATA_W: CPU write data
- `cpu_ack` out 1: one-cycle completion pulse to CPU
- `cpu_rdata` out DATA_W: registered read data for CPU
- `dma_req`, `dma_we`, `dma_addr`, `dma_wdata`, `dma_ack`, `dma_rdata`: same as the CPU port, for DMA
- `mem_en` out 1: memory access strobe, exactly one cycle per access
- `mem_we` out 1: memory write enable, qualified by `mem_en`
- `mem_addr` out ADDR_W: memory address
- `mem_wdata` out DATA_W: memory write data
- `mem_rdata` in DATA_W: memory read data
- `busy` out 1: high in every state except IDLE
- `owner` out 1: port of current/last grant (0 = CPU, 1 = DMA)

## Operation
- FSM states and transitions:
  - IDLE: exits to ISSUE when any `req` is high, otherwise stays.
  - ISSUE: always goes to WAIT.
  - WAIT: lasts exactly `MEM_LAT` cycles, then goes to DONE.
  - DONE: always returns to IDLE.
- IDLE, when any `req` is high:
  - Select the winner and latch its `we`/`addr`/`wdata` into command registers.
  - Update `owner`.
- Arbitration:
  - Only one request high: that port wins.
  - Both high: the port not equal to `owner` wins (round-robin).
- ISSUE:
  - `mem_en` = 1.
  - `mem_we`/`mem_addr`/`mem_wdata` driven from the command registers.
  - Outside ISSUE, `mem_en` = 0 and `mem_we` = 0. Address/data outputs hold their last values.
- WAIT:
  - A down-counter, loaded with `MEM_LAT`-1, counts the cycles.
  - On the last WAIT cycle, a read captures `mem_rdata` into the winner's `rdata` register.
  - Writes capture nothing.
- DONE:
  - The winner's `ack` = 1 for this single cycle.
  - The other port's `ack` stays 0.
- `req` is not sampled in ISSUE, WAIT or DONE. Request inputs may change freely there. Only values present in IDLE matter.
- Requesters must keep request fields stable until `ack`. They must drop `req` (or present a new request) in the cycle after `ack`. Because DONE never samples, a stale `req` seen in the `ack` cycle is never re-granted.
- `cpu_rdata`/`dma_rdata` hold their value until the next read completes on that port. Write completions leave them unchanged.
- A requester that raises `req` while the other is being served waits at most one full access before it is granted.

## Timing
- Reset values (async, while `reset` low):
  - state = IDLE
  - `owner` = 1, so the CPU wins the first simultaneous request
  - `busy` = 0, `mem_en` = 0, `mem_we` = 0
  - `mem_addr` = 0, `mem_wdata` = 0
  - both `ack` = 0, both `rdata` = 0
- Cycle numbering: `req` sampled in IDLE at cycle 0.
  - `mem_en` high in cycle 1.
  - Read data captured at the end of cycle 1+`MEM_LAT`.
  - `ack` high in cycle 2+`MEM_LAT`.
  - `rdata` valid in the same cycle as `ack`.
- Access period: `MEM_LAT`+3 cycles. Back-to-back grants with no idle bubble beyond the IDLE cycle.
- Reset mid-access:
  - The access is aborted and `mem_en` drops asynchronously.
  - No `ack` is issued.
  - A write is lost only if reset arrives before its ISSUE edge.
- `busy` high from cycle 1 through the DONE cycle inclusive.

## Test plan
- Reset with both `req` high, release reset -> CPU granted first (`owner`=0). Single `mem_en` pulse at cycle 1. `cpu_ack` at cycle 3 (`MEM_LAT`=1). `dma_ack` follows 4 cycles later.
- CPU read, `cpu_addr`=0x54, memory returns 0x00000007 -> `mem_addr`=0x54, `mem_we`=0. `cpu_rdata`=0x7 with `cpu_ack` at cycle 3. `dma_rdata` unchanged.
- DMA write 0xDEADBEEF to 0x80 -> exactly one `mem_en` cycle with `mem_we`=1, `mem_wdata`=0xDEADBEEF. `dma_ack` one cycle. `dma_rdata` stays 0.
- Both ports request continuously for 8 accesses -> grants alternate CPU, DMA, CPU…. Each `ack` is 4 cycles apart. No port is ever granted twice in a row.
- `MEM_LAT`=3, CPU read -> `ack` at cycle 5. `mem_rdata` sampled only at the end of cycle 4. Garbage driven on `mem_rdata` in cycles 2–3 is ignored.
- Assert `reset` low during WAIT -> `busy`, `mem_en`, `ack` go 0 immediately. After release, the next IDLE arbitration uses `owner`=1 reset value.
